shift32_seq: RTL

- Multi-cycle, bit-serial counterpart of the combinational SHIFT32 barrel shifter.
- Accepts an operand D, a shift amount S and a direction flag LnR under a START/BUSY/DONE handshake, and shifts one bit position per clock.
- Intended for area-constrained CPU datapath variants and as a cycle-accurate golden model against SHIFT32.
- Y semantics match SHIFT32 exactly: LnR=1 shifts left, LnR=0 shifts right (logical), and any amount of 32 or more yields 0.

---
 rtl/shift32_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift32_seq.sv
// rtl/shift32_seq.sv - bit-serial 32-bit shifter with START/BUSY/DONE handshake (optional rotate: SHIFT32_SEQ_ROTATE_EN)
module shift32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] S,
  input  logic             LnR,
`ifdef SHIFT32_SEQ_ROTATE_EN
  input  logic             ROT,
`endif
  output logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] LP_WIDTH_S = WIDTH;
  localparam logic [CNT_W-1:0] LP_WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LP_ONE_C   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_step;
  logic             w_finish;
  logic             w_rot;
  logic [CNT_W-1:0] w_cnt_init;
  logic [WIDTH-1:0] w_acc_step;

`ifdef SHIFT32_SEQ_ROTATE_EN
  logic r_rot;
  assign w_rot = r_rot;
`else
  assign w_rot = 1'b0;
`endif

  assign Y    = r_y;
  assign BUSY = r_busy;
  assign DONE = r_done;

  // Starting count: saturate at WIDTH for plain shifts (any amount >= WIDTH clears), modulo WIDTH for rotates
  always_comb begin
    w_cnt_init = (S >= LP_WIDTH_S) ? LP_WIDTH_C : S[CNT_W-1:0];
`ifdef SHIFT32_SEQ_ROTATE_EN
    if (ROT) begin
      w_cnt_init = CNT_W'(S % LP_WIDTH_S);
    end
`endif
  end

  // One-position step; fill bit is zero, or the wrapped-around end bit when rotating
  always_comb begin
    w_acc_step = r_acc;
    if (r_dir) begin
      w_acc_step = {r_acc[WIDTH-2:0], (w_rot & r_acc[WIDTH-1])};
    end else begin
      w_acc_step = {(w_rot & r_acc[0]), r_acc[WIDTH-1:1]};
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture at acceptance, shift while counting down, publish result on completion
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_acc  <= '0;
      r_y    <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef SHIFT32_SEQ_ROTATE_EN
      r_rot  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_acc  <= D;
        r_dir  <= LnR;
        r_cnt  <= w_cnt_init;
        r_busy <= 1'b1;
`ifdef SHIFT32_SEQ_ROTATE_EN
        r_rot  <= ROT;
`endif
      end else if (w_step) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt - LP_ONE_C;
      end else if (w_finish) begin
        r_y    <= r_acc;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

endmodule
